// File: rtl/emif_pkg.sv
// Shared types and constants for the EMIF transmit (read-back) register path.
package emif_pkg;

  localparam int EMIF_DATA_WIDTH = 16;
  localparam int EMIF_WORD_WIDTH = 32;
  localparam logic [EMIF_DATA_WIDTH-1:0] EMIF_OOR_VALUE = 16'h0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } emif_state_e;

endpackage

// File: rtl/emif_tx_regs_if.sv
// EMIF pin bundle seen by the read-back responder: the DSP side drives the
// strobes and address, the FPGA side drives the data bus and its tri-state enable.
interface emif_tx_regs_if #(
  parameter int ADDR_WIDTH = 4
);
  import emif_pkg::*;

  logic                       emif_cs_n_i;
  logic                       emif_oe_n_i;
  logic [ADDR_WIDTH-1:0]      emif_addr_i;
  logic [EMIF_DATA_WIDTH-1:0] emif_data_o;
  logic                       emif_data_oe_o;

  modport master (
    output emif_cs_n_i,
    output emif_oe_n_i,
    output emif_addr_i,
    input  emif_data_o,
    input  emif_data_oe_o
  );

  modport slave (
    input  emif_cs_n_i,
    input  emif_oe_n_i,
    input  emif_addr_i,
    output emif_data_o,
    output emif_data_oe_o
  );

endinterface

// File: rtl/emif_strobe_sync.sv
// Multi-flop synchroniser for an active-low EMIF strobe; resets to 1 so the
// strobe reads as inactive while the chain is held in reset.
module emif_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/emif_tx_regs.sv
// EMIF read-back responder: serves 32-bit status words as two 16-bit halves
// with a high-half shadow. Optional snapshot bank under EMIF_TX_SNAPSHOT_EN.
module emif_tx_regs
  import emif_pkg::*;
#(
  parameter int N_WORDS     = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  emif_tx_regs_if.slave                        bus,
  input  logic [N_WORDS*EMIF_WORD_WIDTH-1:0]   words_i,
  input  logic                                 snapshot_i,
  output logic [15:0]                          rd_count_o
);

  localparam int IDX_WIDTH = ADDR_WIDTH - 1;

  logic cs_n_sync;
  logic oe_n_sync;
  logic read_act;

  emif_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (bus.emif_cs_n_i),
    .sync_o  (cs_n_sync)
  );

  emif_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_oe_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (bus.emif_oe_n_i),
    .sync_o  (oe_n_sync)
  );

  assign read_act = !cs_n_sync && !oe_n_sync;

  emif_state_e state_q;
  emif_state_e state_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A strobe released before DRIVE simply returns to IDLE without side effects.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (read_act)  state_d = LATCH;
      LATCH:   state_d = read_act ? DRIVE : IDLE;
      DRIVE:   if (!read_act) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic oe_d;
  logic load_en;
  logic count_en;

  always_comb begin
    oe_d     = (state_d == DRIVE);
    load_en  = (state_q == LATCH);
    count_en = (state_q == RELEASE);
  end

  logic [N_WORDS*EMIF_WORD_WIDTH-1:0] word_src;

`ifdef EMIF_TX_SNAPSHOT_EN
  logic [N_WORDS*EMIF_WORD_WIDTH-1:0] bank_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_q <= '0;
    end else if (snapshot_i) begin
      bank_q <= words_i;
    end
  end

  assign word_src = bank_q;
`else
  logic unused_snapshot;

  assign unused_snapshot = snapshot_i;
  assign word_src        = words_i;
`endif

  logic                       addr_hi;
  logic [IDX_WIDTH-1:0]       addr_idx;
  logic [EMIF_WORD_WIDTH-1:0] sel_word;
  logic                       idx_valid;

  assign addr_hi  = bus.emif_addr_i[0];
  assign addr_idx = bus.emif_addr_i[ADDR_WIDTH-1:1];

  // Indices past the last word leave idx_valid low; the mux never indexes out of range.
  always_comb begin
    sel_word  = '0;
    idx_valid = 1'b0;
    for (int k = 0; k < N_WORDS; k++) begin
      if (int'(addr_idx) == k) begin
        sel_word  = word_src[EMIF_WORD_WIDTH*k +: EMIF_WORD_WIDTH];
        idx_valid = 1'b1;
      end
    end
  end

  logic [EMIF_DATA_WIDTH-1:0] data_q;
  logic [EMIF_DATA_WIDTH-1:0] data_d;
  logic [EMIF_DATA_WIDTH-1:0] shadow_q;
  logic [EMIF_DATA_WIDTH-1:0] shadow_d;

  // High-half reads return the half captured by the last low-half read.
  always_comb begin
    data_d   = data_q;
    shadow_d = shadow_q;
    if (load_en) begin
      if (addr_hi) begin
        data_d = shadow_q;
      end else if (idx_valid) begin
        data_d   = sel_word[EMIF_DATA_WIDTH-1:0];
        shadow_d = sel_word[EMIF_WORD_WIDTH-1:EMIF_DATA_WIDTH];
      end else begin
        data_d = EMIF_OOR_VALUE;
      end
    end
  end

  logic        oe_q;
  logic [15:0] rd_count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q     <= '0;
      shadow_q   <= '0;
      oe_q       <= 1'b0;
      rd_count_q <= '0;
    end else begin
      data_q   <= data_d;
      shadow_q <= shadow_d;
      oe_q     <= oe_d;
      if (count_en) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign bus.emif_data_o    = data_q;
  assign bus.emif_data_oe_o = oe_q;
  assign rd_count_o         = rd_count_q;

endmodule

// File: tb/tb_emif_tx_regs.sv
// Self-checking bench for emif_tx_regs: vector table plus hand-written corner cases.
module tb_emif_tx_regs;
  import emif_pkg::*;

  localparam int N_WORDS     = 6;
  localparam int ADDR_WIDTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int LAT_ON      = SYNC_STAGES + 2;
  localparam int LAT_OFF     = SYNC_STAGES + 1;
  localparam int MAX_WAIT    = 20;
  localparam int N_VECS      = 10;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [N_WORDS*32-1:0]   words_i;
  logic                    snapshot_i;
  logic [15:0]             rd_count_o;

  emif_tx_regs_if #(.ADDR_WIDTH(ADDR_WIDTH)) emif ();

  emif_tx_regs #(
    .N_WORDS     (N_WORDS),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (emif),
    .words_i    (words_i),
    .snapshot_i (snapshot_i),
    .rd_count_o (rd_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr;
    int                    widx;
    logic [31:0]           wval;
    logic [15:0]           exp_data;
  } vec_t;

  vec_t        vecs [N_VECS];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_count;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic pulseSnapshot();
    @(negedge clk_i);
    snapshot_i = 1'b1;
    @(negedge clk_i);
    snapshot_i = 1'b0;
  endtask

  task automatic setWord(input int k, input logic [31:0] val);
    words_i[32*k +: 32] = val;
    pulseSnapshot();
  endtask

  // Full read: checks oe latency, scoreboard data, hold, release latency and count.
  task automatic doRead(input logic [ADDR_WIDTH-1:0] addr, input string name);
    int n;
    @(posedge clk_i);
    #2;
    emif.emif_addr_i = addr;
    emif.emif_cs_n_i = 1'b0;
    emif.emif_oe_n_i = 1'b0;
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (!emif.emif_data_oe_o && n < MAX_WAIT);
    checkOutput({name, "_oe_latency"}, n, LAT_ON);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_scoreboard: got empty queue expected one entry", name);
    end else if (emif.emif_data_oe_o) begin
      checkOutput({name, "_data"}, emif.emif_data_o, exp_q.pop_front());
    end else begin
      void'(exp_q.pop_front());
    end
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput({name, "_oe_hold"}, emif.emif_data_oe_o, 1);
    #1;
    emif.emif_cs_n_i = 1'b1;
    emif.emif_oe_n_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (emif.emif_data_oe_o && n < MAX_WAIT);
    checkOutput({name, "_release_latency"}, n, LAT_OFF);
    repeat (2) @(posedge clk_i);
    #1;
    exp_count = exp_count + 16'd1;
    checkOutput({name, "_count"}, rd_count_o, exp_count);
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    if (v.wr) setWord(v.widx, v.wval);
    exp_q.push_back(v.exp_data);
    doRead(v.addr, name);
  endtask

  task automatic watchNoOe(input string name);
    logic saw;
    saw = 1'b0;
    repeat (10) begin
      @(posedge clk_i);
      #1;
      if (emif.emif_data_oe_o) saw = 1'b1;
    end
    checkOutput({name, "_no_oe"}, saw, 0);
    checkOutput({name, "_count"}, rd_count_o, exp_count);
  endtask

  initial begin
    vecs[0] = '{addr: 4'd4,  wr: 1'b1, widx: 2, wval: 32'h1234_ABCD, exp_data: 16'hABCD};
    vecs[1] = '{addr: 4'd5,  wr: 1'b1, widx: 2, wval: 32'h5555_0000, exp_data: 16'h1234};
    vecs[2] = '{addr: 4'd12, wr: 1'b0, widx: 0, wval: 32'h0,         exp_data: 16'h0000};
    vecs[3] = '{addr: 4'd1,  wr: 1'b0, widx: 0, wval: 32'h0,         exp_data: 16'h1234};
    vecs[4] = '{addr: 4'd10, wr: 1'b0, widx: 0, wval: 32'h0,         exp_data: 16'h5005};
    vecs[5] = '{addr: 4'd11, wr: 1'b0, widx: 0, wval: 32'h0,         exp_data: 16'hA005};
    vecs[6] = '{addr: 4'd15, wr: 1'b0, widx: 0, wval: 32'h0,         exp_data: 16'hA005};
    vecs[7] = '{addr: 4'd0,  wr: 1'b0, widx: 0, wval: 32'h0,         exp_data: 16'h5000};
    vecs[8] = '{addr: 4'd4,  wr: 1'b0, widx: 0, wval: 32'h0,         exp_data: 16'h0000};
    vecs[9] = '{addr: 4'd7,  wr: 1'b0, widx: 0, wval: 32'h0,         exp_data: 16'h5555};

    rst_i            = 1'b1;
    snapshot_i       = 1'b0;
    emif.emif_cs_n_i = 1'b1;
    emif.emif_oe_n_i = 1'b1;
    emif.emif_addr_i = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      words_i[32*k +: 32] = {16'(16'hA000 + k), 16'(16'h5000 + k)};
    end
    exp_count = 16'd0;

    #1;
    checkOutput("reset_data", emif.emif_data_o, 16'h0000);
    checkOutput("reset_oe", emif.emif_data_oe_o, 0);
    checkOutput("reset_count", rd_count_o, 16'h0000);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    pulseSnapshot();

    for (int i = 0; i < N_VECS; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    $display("[TB] short strobe abort");
    @(posedge clk_i);
    #2;
    emif.emif_addr_i = 4'd0;
    emif.emif_cs_n_i = 1'b0;
    emif.emif_oe_n_i = 1'b0;
    @(posedge clk_i);
    #2;
    emif.emif_cs_n_i = 1'b1;
    emif.emif_oe_n_i = 1'b1;
    watchNoOe("abort");

    $display("[TB] oe strobe without chip select");
    @(posedge clk_i);
    #2;
    emif.emif_oe_n_i = 1'b0;
    watchNoOe("no_cs");
    emif.emif_oe_n_i = 1'b1;

    $display("[TB] reset during DRIVE");
    begin
      int n;
      @(posedge clk_i);
      #2;
      emif.emif_addr_i = 4'd0;
      emif.emif_cs_n_i = 1'b0;
      emif.emif_oe_n_i = 1'b0;
      n = 0;
      do begin
        @(posedge clk_i);
        #1;
        n++;
      end while (!emif.emif_data_oe_o && n < MAX_WAIT);
      checkOutput("rst_pre_oe", emif.emif_data_oe_o, 1);
      #1;
      rst_i = 1'b1;
      #1;
      checkOutput("rst_oe", emif.emif_data_oe_o, 0);
      checkOutput("rst_count", rd_count_o, 16'h0000);
      checkOutput("rst_data", emif.emif_data_o, 16'h0000);
      checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
      emif.emif_cs_n_i = 1'b1;
      emif.emif_oe_n_i = 1'b1;
      exp_count = 16'd0;
      @(negedge clk_i);
      rst_i = 1'b0;
      watchNoOe("post_rst");
    end

`ifdef EMIF_TX_SNAPSHOT_EN
    $display("[TB] snapshot coherence and counter wrap");
    setWord(0, 32'hAAAA_0001);
    words_i[31:0] = 32'hBBBB_0002;
    exp_q.push_back(16'h0001);
    doRead(4'd0, "snap_lo");
    exp_q.push_back(16'hAAAA);
    doRead(4'd1, "snap_hi");
    @(negedge clk_i);
    force dut.rd_count_q = 16'hFFFF;
    @(negedge clk_i);
    release dut.rd_count_q;
    exp_count = 16'hFFFF;
    #1;
    checkOutput("wrap_preset", rd_count_o, 16'hFFFF);
    exp_q.push_back(16'h0001);
    doRead(4'd0, "wrap");
`else
    pulseSnapshot();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
